bs_operand_serializer: RTL

Upstream feeder for the bit-serial adder. Accepts a pair of parallel operands over a valid/ready handshake and shifts them out LSB-first on `x` and `y`, one bit per clock. It drives a one-cycle `carry_clr` pulse that connects to the adder's `rst`, so the adder's carry is zero when bit 0 arrives. It also provides `frame` and `last` markers so a downstream capture stage can align the adder's `z` stream.

---
 rtl/bs_operand_serializer_if.sv | 14 +
 rtl/bs_operand_serializer.sv | 79 +++++++
 2 files changed

// File: rtl/bs_operand_serializer_if.sv
// bs_operand_serializer_if: operand handshake and serial output bundle for bs_operand_serializer
interface bs_operand_serializer_if #(parameter int W = 8);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         x;
    logic         y;
    logic         carry_clr;
    logic         frame;
    logic         last;
    modport master (output in_valid, a, b, input in_ready, x, y, carry_clr, frame, last);
    modport slave  (input in_valid, a, b, output in_ready, x, y, carry_clr, frame, last);
endinterface

// File: rtl/bs_operand_serializer.sv
// bs_operand_serializer: LSB-first operand serializer feeding a bit-serial adder.
// Define BS_SER_SIGNEXT_EN to append one sign-extension bit per word (N = W+1).
module bs_operand_serializer #(parameter int W = 8) (
    input logic                    clk,
    input logic                    rst,
    bs_operand_serializer_if.slave s_if
);
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;
`ifdef BS_SER_SIGNEXT_EN
    localparam int N = W + 1;
`else
    localparam int N = W;
`endif
    localparam int CW = $clog2(W + 2);
    localparam logic [CW-1:0] K_LAST = CW'(N - 1);

    state_t        r_state, w_state_n;
    logic [CW-1:0] r_cnt, w_cnt_n;
    logic [W-1:0]  r_a, r_b, w_a_n, w_b_n;
    logic          r_x, r_y, r_clr, r_frame, r_last, r_rdy;
    logic          w_x_n, w_y_n, w_clr_n, w_frame_n, w_last_n, w_rdy_n;
    logic          w_xfer, w_at_last;

    assign w_xfer    = s_if.in_valid && r_rdy;
    assign w_at_last = (r_state == SHIFT) && (r_cnt == K_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_x     <= 1'b0;
            r_y     <= 1'b0;
            r_clr   <= 1'b0;
            r_frame <= 1'b0;
            r_last  <= 1'b0;
            r_rdy   <= 1'b1;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_a     <= w_a_n;
            r_b     <= w_b_n;
            r_x     <= w_x_n;
            r_y     <= w_y_n;
            r_clr   <= w_clr_n;
            r_frame <= w_frame_n;
            r_last  <= w_last_n;
            r_rdy   <= w_rdy_n;
        end
    end

    // Arithmetic right shift: once past the MSB, bit 0 keeps repeating the sign bit.
    always_comb begin
        w_state_n = (r_state == LOAD) ? SHIFT :
                    (r_state == IDLE || w_at_last) ? (w_xfer ? LOAD : IDLE) : r_state;
        w_cnt_n   = (r_state == LOAD) ? '0 :
                    (r_state == SHIFT && !w_at_last) ? r_cnt + 1'b1 : r_cnt;
        w_a_n     = w_xfer ? s_if.a : (r_state == SHIFT) ? {r_a[W-1], r_a[W-1:1]} : r_a;
        w_b_n     = w_xfer ? s_if.b : (r_state == SHIFT) ? {r_b[W-1], r_b[W-1:1]} : r_b;
    end

    // Outputs are decoded from the next state so that the flops present them in step with it.
    always_comb begin
        w_frame_n = (w_state_n == SHIFT);
        w_clr_n   = (w_state_n == LOAD);
        w_x_n     = w_frame_n && w_a_n[0];
        w_y_n     = w_frame_n && w_b_n[0];
        w_last_n  = w_frame_n && (w_cnt_n == K_LAST);
        w_rdy_n   = (w_state_n == IDLE) || w_last_n;
    end

    assign s_if.x         = r_x;
    assign s_if.y         = r_y;
    assign s_if.carry_clr = r_clr;
    assign s_if.frame     = r_frame;
    assign s_if.last      = r_last;
    assign s_if.in_ready  = r_rdy;
endmodule
